// File: rtl/fifo_rd_core.sv
// Read-side core of a gray-pointer FIFO: storage array, read pointer with empty/almost-empty
// flags, and a two-stage return path of the gray read pointer toward the write side.
module fifo_rd_core #(
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned ASIZE       = 4,
  parameter string       FALLTHROUGH = "TRUE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic             wfull,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE:0]   wq2_rptr
);

  localparam int unsigned      Depth  = 1 << ASIZE;
  localparam logic [ASIZE:0]   PtrOne = (ASIZE + 1)'(1);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DSIZE-1:0] mem_q [Depth];

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic           rempty_q, rempty_d;
  logic           arempty_q, arempty_d;
  logic [ASIZE:0] wq1_rptr_q, wq1_rptr_d;
  logic [ASIZE:0] wq2_rptr_q, wq2_rptr_d;
  logic           rd_en;

  // A read while empty is dropped so the pointer can never pass the write pointer.
  always_comb begin
    rd_en      = rinc & ~rempty_q;
    rbin_d     = rbin_q + (rd_en ? PtrOne : '0);
    rptr_d     = bin2gray(rbin_d);
    rempty_d   = (rptr_d == rq2_wptr);
    arempty_d  = (bin2gray(rbin_d + PtrOne) == rq2_wptr);
    wq1_rptr_d = rptr_q;
    wq2_rptr_d = wq1_rptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      arempty_q  <= 1'b0;
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      arempty_q  <= arempty_d;
      wq1_rptr_q <= wq1_rptr_d;
      wq2_rptr_q <= wq2_rptr_d;
    end
  end

  // Storage is deliberately not reset; after a reset stale words are simply unreachable.
  always_ff @(posedge clk) begin
    if (winc && !wfull) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign raddr    = rbin_q[ASIZE-1:0];
  assign rptr     = rptr_q;
  assign rempty   = rempty_q;
  assign arempty  = arempty_q;
  assign wq2_rptr = wq2_rptr_q;

  if (FALLTHROUGH == "TRUE") begin : g_fallthrough
    assign rdata = mem_q[raddr];
  end else begin : g_registered
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rinc) begin
        rdata_d = mem_q[raddr];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_fifo_rd_core.sv
// Bench for fifo_rd_core: fallthrough and registered-read instances on shared stimulus,
// checked every cycle against a count-based model plus pinned literal expectations.
module tb_fifo_rd_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic       wfull = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [4:0] rq2_wptr = '0;
  logic       rinc = 1'b0;

  logic [7:0] ft_rdata, rg_rdata;
  logic       ft_rempty, rg_rempty, ft_arempty, rg_arempty;
  logic [3:0] ft_raddr, rg_raddr;
  logic [4:0] ft_rptr, rg_rptr, ft_wq2, rg_wq2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_rd_core #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE")) u_ft (
    .clk(clk), .rst(rst), .winc(winc), .wfull(wfull), .waddr(waddr), .wdata(wdata),
    .rq2_wptr(rq2_wptr), .rinc(rinc), .rdata(ft_rdata), .rempty(ft_rempty),
    .arempty(ft_arempty), .raddr(ft_raddr), .rptr(ft_rptr), .wq2_rptr(ft_wq2)
  );

  fifo_rd_core #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE")) u_rg (
    .clk(clk), .rst(rst), .winc(winc), .wfull(wfull), .waddr(waddr), .wdata(wdata),
    .rq2_wptr(rq2_wptr), .rinc(rinc), .rdata(rg_rdata), .rempty(rg_rempty),
    .arempty(rg_arempty), .raddr(rg_raddr), .rptr(rg_rptr), .wq2_rptr(rg_wq2)
  );

  function automatic logic [4:0] gray(input int unsigned v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] wval(input int unsigned w);
    return 8'((w * 13 + 5) % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: reads done so far (mod 32), a word store, and the pointer history.
  int unsigned m_cnt = 0;
  bit          m_init = 1'b0;
  bit          m_empty = 1'b1, m_aempty = 1'b0;
  logic [4:0]  m_wq1 = '0, m_wq2 = '0;
  logic [7:0]  m_mem [16];
  bit          m_vld [16];
  logic [7:0]  m_rdata = '0;
  bit          m_rvld = 1'b0;

  always @(posedge clk) begin : model
    int unsigned n;
    if (rst) begin
      m_cnt    <= 0;
      m_empty  <= 1'b1;
      m_aempty <= 1'b0;
      m_wq1    <= '0;
      m_wq2    <= '0;
      m_rdata  <= '0;
      m_rvld   <= 1'b1;
      m_init   <= 1'b1;
    end else begin
      n = (m_cnt + ((rinc && !m_empty) ? 1 : 0)) % 32;
      m_cnt    <= n;
      m_empty  <= (gray(n) == rq2_wptr);
      m_aempty <= (gray(n + 1) == rq2_wptr);
      m_wq1    <= gray(m_cnt);
      m_wq2    <= m_wq1;
      if (rinc) begin
        m_rdata <= m_mem[m_cnt % 16];
        m_rvld  <= m_vld[m_cnt % 16];
      end
    end
    if (winc && !wfull) begin
      m_mem[waddr] <= wdata;
      m_vld[waddr] <= 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    if (m_init) begin
      chk("ft_rempty", 32'(ft_rempty), 32'(m_empty));
      chk("rg_rempty", 32'(rg_rempty), 32'(m_empty));
      chk("ft_arempty", 32'(ft_arempty), 32'(m_aempty));
      chk("rg_arempty", 32'(rg_arempty), 32'(m_aempty));
      chk("ft_rptr", 32'(ft_rptr), 32'(gray(m_cnt)));
      chk("rg_rptr", 32'(rg_rptr), 32'(gray(m_cnt)));
      chk("ft_raddr", 32'(ft_raddr), m_cnt % 16);
      chk("rg_raddr", 32'(rg_raddr), m_cnt % 16);
      chk("ft_wq2", 32'(ft_wq2), 32'(m_wq2));
      chk("rg_wq2", 32'(rg_wq2), 32'(m_wq2));
      if (!m_empty && m_vld[m_cnt % 16]) chk("ft_rdata", 32'(ft_rdata), 32'(m_mem[m_cnt % 16]));
      if (m_rvld) chk("rg_rdata", 32'(rg_rdata), 32'(m_rdata));
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int guard;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_rempty", 32'(ft_rempty), 32'h1);
    chk("rst_arempty", 32'(ft_arempty), 32'h0);
    chk("rst_rptr", 32'(ft_rptr), 32'h0);
    chk("rst_raddr", 32'(rg_raddr), 32'h0);
    chk("rst_wq2", 32'(rg_wq2), 32'h0);

    // One word, then expose it through the synchronized write pointer.
    winc = 1'b1; waddr = 4'd0; wdata = 8'hA5; rq2_wptr = 5'd0;
    step();
    winc = 1'b0; rq2_wptr = 5'd1;
    step();
    chk("one_rempty", 32'(ft_rempty), 32'h0);
    chk("one_arempty", 32'(ft_arempty), 32'h1);
    chk("one_ft_rdata", 32'(ft_rdata), 32'hA5);
    chk("one_rg_rdata_before", 32'(rg_rdata), 32'h0);
    rinc = 1'b1;
    step();
    chk("rd_rptr", 32'(ft_rptr), 32'h1);
    chk("rd_rempty", 32'(ft_rempty), 32'h1);
    chk("rd_rg_rdata", 32'(rg_rdata), 32'hA5);

    // Underflow: rinc held while empty.
    step();
    chk("wq2_lag1", 32'(ft_wq2), 32'h0);
    step();
    chk("wq2_lag2", 32'(ft_wq2), 32'h1);
    step();
    chk("uf_rptr", 32'(rg_rptr), 32'h1);
    chk("uf_rempty", 32'(rg_rempty), 32'h1);

    // Streaming writes and reads through a full pointer wrap.
    for (int w = 1; w < 32; w++) begin
      winc = 1'b1; waddr = 4'(w % 16); wdata = wval(w); rq2_wptr = gray(w); rinc = 1'b1;
      step();
      if (m_cnt == 15) chk("wrap_rptr15", 32'(ft_rptr), 32'h08);
      if (m_cnt == 16) begin
        chk("wrap_rptr16", 32'(ft_rptr), 32'h18);
        chk("wrap_raddr16", 32'(ft_raddr), 32'h0);
      end
    end
    winc = 1'b0; rq2_wptr = gray(32);
    repeat (8) step();
    chk("wrap32_rptr", 32'(ft_rptr), 32'h0);
    chk("wrap32_raddr", 32'(ft_raddr), 32'h0);
    chk("wrap32_rempty", 32'(ft_rempty), 32'h1);

    // Overflow attempt at address 3 must leave the older word in place.
    rinc = 1'b0;
    winc = 1'b1; wfull = 1'b1; waddr = 4'd3; wdata = 8'hFF;
    step();
    wfull = 1'b0;
    for (int w = 32; w < 35; w++) begin
      waddr = 4'(w % 16); wdata = wval(w);
      step();
    end
    winc = 1'b0; rq2_wptr = gray(36); rinc = 1'b1;
    guard = 0;
    while (m_cnt != 3 && guard < 10) begin
      step();
      guard++;
    end
    chk("ovf_reached", 32'(m_cnt), 32'd3);
    chk("ovf_mem3", 32'(ft_rdata), 32'hFC);
    step();
    chk("ovf_rg_mem3", 32'(rg_rdata), 32'hFC);
    rinc = 1'b0;
    step();

    // Reset in the middle of operation.
    rq2_wptr = gray(8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rq2_wptr = 5'd0;
    chk("mid_rst_rptr", 32'(ft_rptr), 32'h0);
    chk("mid_rst_rempty", 32'(rg_rempty), 32'h1);
    chk("mid_rst_rg_rdata", 32'(rg_rdata), 32'h0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
